fft_input_loader: RTL and testbench

Input stage that sits directly upstream of the 4-bank complex sample RAM. It accepts a serial stream of complex time-domain samples through a valid/ready handshake and sign-extends each sample from IN_BIT to D_BIT. Each sample is written into one of the 4 banks at its radix-4 digit-reversed position, so the butterfly stages can read in natural order. It signals completion once all N = 4*2^A_BIT samples are stored.

---
 rtl/fft_input_loader.sv | 130 +++++++++++++
 tb/tb_fft_input_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Front end of the FFT. It accepts a frame of N = 2^(A_BIT+2) complex
//   samples over a valid/ready handshake and sign-extends each one from
//   IN_BIT to D_BIT. Each sample is written into one of four sample-RAM
//   banks at its radix-4 digit-reversed position, so the butterfly stages
//   can read the frame in natural order.
//
// Ports
//   iCLK, iRST          clock (rising edge), synchronous active-high reset
//   iSTART              frame start request, honoured only while idle
//   iVALID, oREADY      sample handshake; a transfer is iVALID & oREADY
//   iDATA_RE/IM         signed IN_BIT input sample
//   oDATA_RE/IM         sign-extended D_BIT sample, shared by all banks
//   oADDR_WR            bank write address, shared by all banks
//   oWE_0..oWE_3        one-hot per-bank write enables
//   oBUSY, oDONE        frame in progress / one-cycle completion pulse
module fft_input_loader #(
  parameter int IN_BIT = 16,
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 10
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iVALID,
  input  logic [IN_BIT-1:0] iDATA_RE,
  input  logic [IN_BIT-1:0] iDATA_IM,
  output logic              oREADY,
  output logic [D_BIT-1:0]  oDATA_RE,
  output logic [D_BIT-1:0]  oDATA_IM,
  output logic [A_BIT-1:0]  oADDR_WR,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int NB = A_BIT + 2;   // sample index width
  localparam int ND = NB / 2;      // radix-4 digits per index
  localparam logic [NB-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t state, stateNext;
  logic [NB-1:0] sampleIdx;
  logic [NB-1:0] revIdx;
  logic          readyInt;
  logic          xfer;

  logic signed [D_BIT-1:0] dataRe_p1;
  logic signed [D_BIT-1:0] dataIm_p1;
  logic        [A_BIT-1:0] addr_p1;
  logic        [3:0]       we_p1;

  // Base-4 digit i of v moves to digit ND-1-i of the result.
  function automatic logic [NB-1:0] digitRev(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[2*(ND-1-i) +: 2] = v[2*i +: 2];
    end
    return r;
  endfunction

  // Plain sign extension: the extra MSBs are headroom for FFT growth.
  function automatic logic signed [D_BIT-1:0] signExt(input logic signed [IN_BIT-1:0] v);
    logic signed [D_BIT-1:0] r;
    r = v;
    return r;
  endfunction

  // Reset wins over a handshake in the same cycle.
  assign readyInt = (state == LOAD) && !iRST;
  assign xfer     = iVALID && readyInt;
  assign revIdx   = digitRev(sampleIdx);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iSTART) stateNext = LOAD;
      LOAD:    if (xfer && sampleIdx == LAST_IDX) stateNext = FLUSH;
      FLUSH:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The counter holds at N-1 on the final transfer instead of wrapping.
  always_ff @(posedge iCLK) begin
    if (iRST)                         sampleIdx <= '0;
    else if (state == IDLE && iSTART) sampleIdx <= '0;
    else if (xfer && sampleIdx != LAST_IDX) sampleIdx <= sampleIdx + 1'b1;
  end

  // ---- stage p1: registered bank write ----
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      we_p1     <= '0;
      addr_p1   <= '0;
      dataRe_p1 <= '0;
      dataIm_p1 <= '0;
    end else begin
      we_p1 <= xfer ? (4'b0001 << revIdx[1:0]) : 4'b0000;
      if (xfer) begin
        addr_p1   <= revIdx[NB-1:2];
        dataRe_p1 <= signExt(iDATA_RE);
        dataIm_p1 <= signExt(iDATA_IM);
      end
    end
  end

  assign oREADY   = readyInt;
  assign oBUSY    = (state != IDLE);
  assign oDONE    = (state == DONE);
  assign oDATA_RE = dataRe_p1;
  assign oDATA_IM = dataIm_p1;
  assign oADDR_WR = addr_p1;
  assign oWE_0    = we_p1[0];
  assign oWE_1    = we_p1[1];
  assign oWE_2    = we_p1[2];
  assign oWE_3    = we_p1[3];

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

  localparam int IN_BIT = 16;
  localparam int D_BIT  = 17;
  localparam int A_BIT  = 10;
  localparam int N      = 4096;
  localparam int GUARD  = 20000;

  logic              iCLK = 1'b0;
  logic              iRST, iSTART, iVALID;
  logic [IN_BIT-1:0] iDATA_RE, iDATA_IM;
  logic              oREADY, oBUSY, oDONE;
  logic [D_BIT-1:0]  oDATA_RE, oDATA_IM;
  logic [A_BIT-1:0]  oADDR_WR;
  logic              oWE_0, oWE_1, oWE_2, oWE_3;

  always #5 iCLK = ~iCLK;

  fft_input_loader #(.IN_BIT(IN_BIT), .D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iVALID(iVALID),
    .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM), .oREADY(oREADY),
    .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM), .oADDR_WR(oADDR_WR),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  typedef struct {
    int               n;
    logic [1:0]       bank;
    logic [A_BIT-1:0] addr;
    logic [D_BIT-1:0] re;
    logic [D_BIT-1:0] im;
  } wr_t;

  wr_t expQ[$];
  int  nErr = 0;
  int  nChk = 0;
  int  mState = 0;   // 0 idle, 1 load, 2 flush, 3 done
  int  mN = 0;
  int  wrCnt[4][1024];

  int mapN[7] = '{0, 1, 3, 5, 1024, 3072, 4095};
  int mapB[7] = '{0, 0, 0, 0, 1,    3,    3};
  int mapA[7] = '{0, 256, 768, 320, 0, 0, 1023};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reverse the six base-4 digits of n arithmetically.
  function automatic int revModel(input int n);
    int r, v;
    r = 0;
    v = n;
    for (int i = 0; i < 6; i++) begin
      r = r * 4 + (v % 4);
      v = v / 4;
    end
    return r;
  endfunction

  // Drive one cycle at the falling edge, predict, then check after the next rising edge.
  task automatic cycle(input logic st, input logic vl, input logic rs,
                       input logic [15:0] re, input logic [15:0] im);
    wr_t  e;
    logic rdy;
    int   r, b;
    logic [3:0] we;
    iSTART = st; iVALID = vl; iRST = rs; iDATA_RE = re; iDATA_IM = im;
    #1;
    rdy = (mState == 1) && !rs;
    if (!rs) begin
      chk("ready", oREADY, rdy);
      chk("busy",  oBUSY,  mState != 0);
      chk("done",  oDONE,  mState == 3);
    end
    if (vl && rdy) begin
      r = revModel(mN);
      e.n    = mN;
      e.bank = 2'(r % 4);
      e.addr = 10'(r / 4);
      e.re   = {re[15], re};
      e.im   = {im[15], im};
      expQ.push_back(e);
    end
    if (rs) begin
      mState = 0; mN = 0;
    end else begin
      case (mState)
        0: if (st) begin mState = 1; mN = 0; end
        1: if (vl) begin
             if (mN == N - 1) mState = 2;
             else mN++;
           end
        2: mState = 3;
        default: mState = 0;
      endcase
    end
    @(posedge iCLK);
    @(negedge iCLK);
    we = {oWE_3, oWE_2, oWE_1, oWE_0};
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("we",      we,       4'b0001 << e.bank);
      chk("addr",    oADDR_WR, e.addr);
      chk("data_re", oDATA_RE, e.re);
      chk("data_im", oDATA_IM, e.im);
      for (int k = 0; k < 7; k++) begin
        if (e.n == mapN[k]) begin
          chk("map_we",   we,       4'b0001 << mapB[k]);
          chk("map_addr", oADDR_WR, mapA[k]);
        end
      end
      b = (we == 4'b0001) ? 0 : (we == 4'b0010) ? 1 : (we == 4'b0100) ? 2 :
          (we == 4'b1000) ? 3 : -1;
      if (b >= 0) wrCnt[b][oADDR_WR]++;
    end else begin
      chk("we_idle", we, 4'b0000);
    end
  endtask

  task automatic frame(input bit gaps, input int abortAt, input bit sextTest);
    int   guard, ones;
    logic vl, st;
    bit   aborted;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 1024; a++) wrCnt[b][a] = 0;
    // Start and valid together: the sample is not taken.
    cycle(1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    guard   = 0;
    aborted = 0;
    while (mState != 0 && guard < GUARD) begin
      vl = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      st = (mState == 3) || (mState == 1 && mN == 50);
      if (abortAt > 0 && mState == 1 && mN == abortAt) begin
        cycle(1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
        chk("abort_addr", oADDR_WR, 0);
        chk("abort_re",   oDATA_RE, 0);
        chk("abort_im",   oDATA_IM, 0);
        aborted = 1;
      end else if (sextTest && mState == 1 && mN == 0 && vl) begin
        cycle(st, vl, 1'b0, 16'h8000, 16'h7FFF);
        chk("sext_re", oDATA_RE, 17'h18000);
        chk("sext_im", oDATA_IM, 17'h07FFF);
      end else begin
        cycle(st, vl, 1'b0, 16'($urandom), 16'($urandom));
      end
      guard++;
    end
    chk("frame_bound", guard < GUARD, 1'b1);
    if (!aborted) begin
      for (int b = 0; b < 4; b++) begin
        ones = 0;
        for (int a = 0; a < 1024; a++) if (wrCnt[b][a] == 1) ones++;
        chk("bank_cov", ones, 1024);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    iRST = 1'b1; iSTART = 1'b0; iVALID = 1'b0; iDATA_RE = '0; iDATA_IM = '0;
    @(negedge iCLK);
    cycle(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    chk("rst_re",   oDATA_RE, 0);
    chk("rst_im",   oDATA_IM, 0);
    chk("rst_addr", oADDR_WR, 0);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
    chk("idle_addr", oADDR_WR, 0);
    chk("idle_re",   oDATA_RE, 0);

    frame(1'b0, 0,   1'b1);   // continuous valid, ignored starts
    frame(1'b1, 0,   1'b0);   // random valid gaps
    frame(1'b1, 100, 1'b0);   // reset after 100 transfers
    frame(1'b1, 0,   1'b1);   // restart after abort

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
